// File: rtl/img_pipe_pkg.sv
// Shared constants and types for the mask image pipeline and its host register stage.
// Frame geometry, coordinate/count/sum widths and the extractor FSM encoding.
// Widths are sized so that no accumulator can overflow for a full frame.
package img_pipe_pkg;

    localparam int IMG_W    = 30;
    localparam int IMG_H    = 30;
    localparam int IMG_SIZE = IMG_W * IMG_H;

    // 2^COORD_W >= max(IMG_W, IMG_H)
    localparam int COORD_W  = 5;
    // 2^CNT_W > IMG_SIZE
    localparam int CNT_W    = 10;
    // holds (max coord) * IMG_SIZE
    localparam int SUM_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/bbox_accum.sv
// Per-pixel foreground accumulator: bounding box, pixel count and coordinate sums.
// Next-value outputs are combinational so the caller can capture a frame's final pixel.
// clr_i wins over en_i; min registers clear to all-ones, everything else to zero.
module bbox_accum
    import img_pipe_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [COORD_W-1:0] x_min_d_o,
    output logic [COORD_W-1:0] x_max_d_o,
    output logic [COORD_W-1:0] y_min_d_o,
    output logic [COORD_W-1:0] y_max_d_o,
    output logic [CNT_W-1:0]   count_d_o,
    output logic [SUM_W-1:0]   sum_x_d_o,
    output logic [SUM_W-1:0]   sum_y_d_o
);

    logic [COORD_W-1:0] x_min_q, x_max_q, y_min_q, y_max_q;
    logic [CNT_W-1:0]   count_q;
    logic [SUM_W-1:0]   sum_x_q, sum_y_q;

    // Fold the current foreground pixel into the running statistics.
    always_comb begin
        x_min_d_o = x_min_q;
        x_max_d_o = x_max_q;
        y_min_d_o = y_min_q;
        y_max_d_o = y_max_q;
        count_d_o = count_q;
        sum_x_d_o = sum_x_q;
        sum_y_d_o = sum_y_q;
        if (en_i) begin
            if (x_i < x_min_q) x_min_d_o = x_i;
            if (x_i > x_max_q) x_max_d_o = x_i;
            if (y_i < y_min_q) y_min_d_o = y_i;
            if (y_i > y_max_q) y_max_d_o = y_i;
            count_d_o = count_q + CNT_W'(1);
            sum_x_d_o = sum_x_q + SUM_W'(x_i);
            sum_y_d_o = sum_y_q + SUM_W'(y_i);
        end
    end

    // Statistic registers with frame-level clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_min_q <= '1;
            x_max_q <= '0;
            y_min_q <= '1;
            y_max_q <= '0;
            count_q <= '0;
            sum_x_q <= '0;
            sum_y_q <= '0;
        end else if (clr_i) begin
            x_min_q <= '1;
            x_max_q <= '0;
            y_min_q <= '1;
            y_max_q <= '0;
            count_q <= '0;
            sum_x_q <= '0;
            sum_y_q <= '0;
        end else begin
            x_min_q <= x_min_d_o;
            x_max_q <= x_max_d_o;
            y_min_q <= y_min_d_o;
            y_max_q <= y_max_d_o;
            count_q <= count_d_o;
            sum_x_q <= sum_x_d_o;
            sum_y_q <= sum_y_d_o;
        end
    end

endmodule

// File: rtl/mask_bbox_extractor.sv
// Pops one mask byte per pixel of a raster-order frame and emits bbox/count/centroid sums per frame.
// Result valid 2 cycles after the last FIFO pop; gaps in the FIFO simply stall the frame.
// While a record waits for res_ready no pixels are popped, which back-pressures the FIFO.
module mask_bbox_extractor
    import img_pipe_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_rst_n,
    input  logic [7:0]         mask_fifo_dout,
    input  logic               mask_fifo_empty,
    output logic               mask_fifo_rd_en,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_found,
    output logic [COORD_W-1:0] res_x_min,
    output logic [COORD_W-1:0] res_x_max,
    output logic [COORD_W-1:0] res_y_min,
    output logic [COORD_W-1:0] res_y_max,
    output logic [CNT_W-1:0]   res_count,
    output logic [SUM_W-1:0]   res_sum_x,
    output logic [SUM_W-1:0]   res_sum_y
);

    state_t             state_q;
    logic [CNT_W-1:0]   issued_q;
    logic               pix_vld_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic               res_valid_q, res_found_q;
    logic [COORD_W-1:0] res_x_min_q, res_x_max_q, res_y_min_q, res_y_max_q;
    logic [CNT_W-1:0]   res_count_q;
    logic [SUM_W-1:0]   res_sum_x_q, res_sum_y_q;

    logic               acc_clr, acc_en, found_d;
    logic [COORD_W-1:0] x_min_d, x_max_d, y_min_d, y_max_d;
    logic [CNT_W-1:0]   count_d;
    logic [SUM_W-1:0]   sum_x_d, sum_y_d;

    assign mask_fifo_rd_en = (state_q == ST_READ) && !mask_fifo_empty
                             && (issued_q < CNT_W'(IMG_SIZE));

    // Accumulators restart on soft reset and when a record is handed off.
    assign acc_clr = !s_rst_n || ((state_q == ST_OUT) && res_valid_q && res_ready);
    assign acc_en  = pix_vld_q && (mask_fifo_dout != 8'd0);
    assign found_d = (count_d != '0);

    bbox_accum u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (acc_clr),
        .en_i      (acc_en),
        .x_i       (x_q),
        .y_i       (y_q),
        .x_min_d_o (x_min_d),
        .x_max_d_o (x_max_d),
        .y_min_d_o (y_min_d),
        .y_max_d_o (y_max_d),
        .count_d_o (count_d),
        .sum_x_d_o (sum_x_d),
        .sum_y_d_o (sum_y_d)
    );

    // Frame FSM, pop counter, raster coordinates and the registered result record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            issued_q    <= '0;
            pix_vld_q   <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            res_valid_q <= 1'b0;
            res_found_q <= 1'b0;
            res_x_min_q <= '0;
            res_x_max_q <= '0;
            res_y_min_q <= '0;
            res_y_max_q <= '0;
            res_count_q <= '0;
            res_sum_x_q <= '0;
            res_sum_y_q <= '0;
        end else if (!s_rst_n) begin
            state_q     <= ST_IDLE;
            issued_q    <= '0;
            pix_vld_q   <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            res_valid_q <= 1'b0;
            res_found_q <= 1'b0;
            res_x_min_q <= '0;
            res_x_max_q <= '0;
            res_y_min_q <= '0;
            res_y_max_q <= '0;
            res_count_q <= '0;
            res_sum_x_q <= '0;
            res_sum_y_q <= '0;
        end else begin
            // FIFO data arrives one cycle after the pop.
            pix_vld_q <= mask_fifo_rd_en;
            if (pix_vld_q) begin
                if (x_q == COORD_W'(IMG_W - 1)) begin
                    x_q <= '0;
                    y_q <= y_q + COORD_W'(1);
                end else begin
                    x_q <= x_q + COORD_W'(1);
                end
            end
            case (state_q)
                ST_IDLE: state_q <= ST_READ;
                ST_READ: begin
                    if (mask_fifo_rd_en) begin
                        issued_q <= issued_q + CNT_W'(1);
                        if (issued_q == CNT_W'(IMG_SIZE - 1)) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Only one pop can be outstanding here, so this is the final pixel.
                    if (pix_vld_q) begin
                        res_valid_q <= 1'b1;
                        res_found_q <= found_d;
                        res_x_min_q <= found_d ? x_min_d : '0;
                        res_x_max_q <= found_d ? x_max_d : '0;
                        res_y_min_q <= found_d ? y_min_d : '0;
                        res_y_max_q <= found_d ? y_max_d : '0;
                        res_count_q <= count_d;
                        res_sum_x_q <= sum_x_d;
                        res_sum_y_q <= sum_y_d;
                        state_q     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        issued_q    <= '0;
                        x_q         <= '0;
                        y_q         <= '0;
                        state_q     <= ST_READ;
                    end
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_found = res_found_q;
    assign res_x_min = res_x_min_q;
    assign res_x_max = res_x_max_q;
    assign res_y_min = res_y_min_q;
    assign res_y_max = res_y_max_q;
    assign res_count = res_count_q;
    assign res_sum_x = res_sum_x_q;
    assign res_sum_y = res_sum_y_q;

endmodule

// File: tb/tb_mask_bbox_extractor.sv
// Bench for mask_bbox_extractor: FIFO model fed from a byte queue, frame-level reference model.
// Records are compared on appearance, checked for stability while stalled, and timed against the last pop.
// Ready is driven constant, random, or held low for a fixed stall after a record appears.
`timescale 1ns/1ps
module tb_mask_bbox_extractor;
    import img_pipe_pkg::*;

    typedef struct packed {
        logic               found;
        logic [COORD_W-1:0] x_min;
        logic [COORD_W-1:0] x_max;
        logic [COORD_W-1:0] y_min;
        logic [COORD_W-1:0] y_max;
        logic [CNT_W-1:0]   count;
        logic [SUM_W-1:0]   sum_x;
        logic [SUM_W-1:0]   sum_y;
    } rec_t;

    logic               clk, rst_n, s_rst_n;
    logic [7:0]         mask_fifo_dout;
    logic               mask_fifo_empty, mask_fifo_rd_en;
    logic               res_valid, res_ready, res_found;
    logic [COORD_W-1:0] res_x_min, res_x_max, res_y_min, res_y_max;
    logic [CNT_W-1:0]   res_count;
    logic [SUM_W-1:0]   res_sum_x, res_sum_y;

    mask_bbox_extractor dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_rst_n         (s_rst_n),
        .mask_fifo_dout  (mask_fifo_dout),
        .mask_fifo_empty (mask_fifo_empty),
        .mask_fifo_rd_en (mask_fifo_rd_en),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_found       (res_found),
        .res_x_min       (res_x_min),
        .res_x_max       (res_x_max),
        .res_y_min       (res_y_min),
        .res_y_max       (res_y_max),
        .res_count       (res_count),
        .res_sum_x       (res_sum_x),
        .res_sum_y       (res_sum_y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] fifo_q [$];
    rec_t       exp_q  [$];
    logic [7:0] fr [IMG_SIZE];
    int         gap_pct    = 0;
    bit         rand_ready = 0;
    int         hold_cnt   = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Frame-level reference: scan the whole image in raster order.
    function automatic rec_t model(input logic [7:0] f [IMG_SIZE]);
        rec_t r;
        int xmn = IMG_W, xmx = -1, ymn = IMG_H, ymx = -1, n = 0, sx = 0, sy = 0;
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++)
                if (f[y*IMG_W + x] != 8'd0) begin
                    n++; sx += x; sy += y;
                    if (x < xmn) xmn = x;
                    if (x > xmx) xmx = x;
                    if (y < ymn) ymn = y;
                    if (y > ymx) ymx = y;
                end
        r = '0;
        if (n > 0) begin
            r.found = 1'b1;
            r.x_min = COORD_W'(xmn); r.x_max = COORD_W'(xmx);
            r.y_min = COORD_W'(ymn); r.y_max = COORD_W'(ymx);
        end
        r.count = CNT_W'(n);
        r.sum_x = SUM_W'(sx);
        r.sum_y = SUM_W'(sy);
        return r;
    endfunction

    function automatic rec_t mk(input int f, input int xa, input int xb, input int ya, input int yb,
                                input int n, input int sx, input int sy);
        rec_t r;
        r.found = f[0];
        r.x_min = COORD_W'(xa); r.x_max = COORD_W'(xb);
        r.y_min = COORD_W'(ya); r.y_max = COORD_W'(yb);
        r.count = CNT_W'(n);
        r.sum_x = SUM_W'(sx); r.sum_y = SUM_W'(sy);
        return r;
    endfunction

    task automatic pin(input rec_t req, input string name);
        rec_t m;
        m = model(fr);
        chk(m == req, name, 64'(m), 64'(req));
    endtask

    task automatic push_frame();
        for (int i = 0; i < IMG_SIZE; i++) fifo_q.push_back(fr[i]);
        exp_q.push_back(model(fr));
    endtask

    task automatic fill_random();
        int p;
        p = $urandom_range(100);
        for (int i = 0; i < IMG_SIZE; i++)
            fr[i] = ($urandom_range(99) < p) ? 8'($urandom_range(255, 1)) : 8'd0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || res_valid) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk(t < 20000, name, 64'(t), 64'd20000);
        repeat (3) @(negedge clk);
    endtask

    // FIFO model and ready generator: present popped data one cycle after each pop.
    initial begin
        bit pend = 0;
        mask_fifo_empty = 1'b1;
        mask_fifo_dout  = 8'd0;
        res_ready       = 1'b1;
        forever begin
            @(negedge clk);
            if (pend && fifo_q.size() > 0) mask_fifo_dout = fifo_q.pop_front();
            else                           mask_fifo_dout = 8'($urandom);
            mask_fifo_empty = (fifo_q.size() == 0) || ($urandom_range(99) < gap_pct);
            if (hold_cnt > 0) begin
                res_ready = 1'b0;
                if (res_valid) hold_cnt--;
            end else begin
                res_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
            end
            #1 pend = mask_fifo_rd_en && !mask_fifo_empty && rst_n;
        end
    end

    // Output monitor: checks pop gating, record contents, latency and stall stability.
    initial begin
        int   cyc = 0, pops = 0, last_pop = -100;
        bit   prev_vld = 0, prev_rdy = 0;
        rec_t cur, held;
        held = '0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst_n) begin
                cur = {res_found, res_x_min, res_x_max, res_y_min, res_y_max, res_count, res_sum_x, res_sum_y};
                if (mask_fifo_rd_en) begin
                    chk(!mask_fifo_empty, "rd_en_while_empty", 64'(mask_fifo_empty), 64'd0);
                    chk(!res_valid, "rd_en_while_record_pending", 64'(res_valid), 64'd0);
                end
                if (mask_fifo_rd_en && !mask_fifo_empty) begin
                    pops++;
                    if (pops == IMG_SIZE) begin
                        last_pop = cyc;
                        pops = 0;
                    end
                end
                if (!s_rst_n) pops = 0;
                if (prev_vld && !prev_rdy) begin
                    chk(res_valid && cur == held, "stall_stable", 64'(cur), 64'(held));
                end else if (res_valid) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_record", 64'(cur), 64'd0);
                    end else begin
                        rec_t e;
                        e = exp_q.pop_front();
                        chk(cur == e, "record", 64'(cur), 64'(e));
                        chk(cyc == last_pop + 2, "latency", 64'(cyc - last_pop), 64'd2);
                    end
                end
                prev_vld = res_valid;
                prev_rdy = res_ready;
                held     = cur;
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        s_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk({res_valid, res_found, res_x_min, res_x_max, res_y_min, res_y_max, res_count, res_sum_x, res_sum_y} == '0,
            "reset_outputs",
            64'({res_found, res_x_min, res_x_max, res_y_min, res_y_max, res_count, res_sum_x, res_sum_y}), 64'd0);
        chk(!mask_fifo_rd_en, "reset_rd_en", 64'(mask_fifo_rd_en), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-background frame.
        for (int i = 0; i < IMG_SIZE; i++) fr[i] = 8'd0;
        pin(mk(0, 0, 0, 0, 0, 0, 0, 0), "model_empty");
        push_frame();
        wait_drain("timeout_empty");

        // Single foreground pixel at (7,12).
        fr[12*IMG_W + 7] = 8'hFF;
        pin(mk(1, 7, 7, 12, 12, 1, 7, 12), "model_single");
        push_frame();
        wait_drain("timeout_single");

        // Full foreground frame.
        for (int i = 0; i < IMG_SIZE; i++) fr[i] = 8'hFF;
        pin(mk(1, 0, 29, 0, 29, 900, 13050, 13050), "model_full");
        push_frame();
        wait_drain("timeout_full");

        // Rectangle x 3..10, y 5..8 with FIFO gaps.
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++)
                fr[y*IMG_W + x] = (x >= 3 && x <= 10 && y >= 5 && y <= 8) ? 8'($urandom_range(255, 1)) : 8'd0;
        pin(mk(1, 3, 10, 5, 8, 32, 208, 208), "model_rect");
        gap_pct = 35;
        push_frame();
        wait_drain("timeout_rect");

        // Two back-to-back frames, first record stalled for 20 cycles.
        gap_pct  = 10;
        hold_cnt = 20;
        fill_random();
        push_frame();
        fill_random();
        push_frame();
        wait_drain("timeout_b2b");

        // Abort frame A half way, then a full frame B.
        gap_pct = 20;
        fill_random();
        for (int i = 0; i < IMG_SIZE/2; i++) fifo_q.push_back(fr[i]);
        begin
            int t = 0;
            while (fifo_q.size() != 0 && t < 5000) begin
                @(negedge clk);
                t++;
            end
            chk(t < 5000, "timeout_abort", 64'(t), 64'd5000);
        end
        repeat (3) @(negedge clk);
        s_rst_n = 1'b0;
        @(negedge clk);
        s_rst_n = 1'b1;
        fill_random();
        fr[0] = 8'h01;
        push_frame();
        wait_drain("timeout_after_abort");

        // Random frames with random gaps and random ready.
        gap_pct    = 40;
        rand_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fill_random();
            push_frame();
        end
        wait_drain("timeout_random");

        chk(exp_q.size() == 0, "records_outstanding", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
